axi_lite_cmd_master: RTL and testbench

// Sequences single AXI4-lite transactions from a simple command stream toward one AXI4-lite slave.

---
 rtl/axi_lite_cmd_master.sv | 189 ++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-lite master driven by a {write, addr, wdata} command stream.
// A watchdog turns a stalled slave into a timeout response; the late beat is drained afterwards.
module axi_lite_cmd_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_tvalid,
  input  logic        rsp_tready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic        rsp_timeout,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESP, DRAIN
  } state_t;

  state_t         state_q;
  logic [WDW-1:0] wdog_q;
  logic [WDW-1:0] wdog_d;
  logic           cmd_tready_q;
  logic           awvalid_q;
  logic           wvalid_q;
  logic           arvalid_q;
  logic           bready_q;
  logic           rready_q;
  logic           is_wr_q;
  logic           rsp_tvalid_q;
  logic           rsp_timeout_q;
  logic [1:0]     rsp_status_q;
  logic [31:0]    rsp_rdata_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, wdog_fire;

  assign aw_hs     = awvalid_q & m_axi_awready;
  assign w_hs      = wvalid_q  & m_axi_wready;
  assign ar_hs     = arvalid_q & m_axi_arready;
  assign b_hs      = bready_q  & m_axi_bvalid;
  assign r_hs      = rready_q  & m_axi_rvalid;
  assign wdog_d    = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
  assign wdog_fire = (TIMEOUT != 0) && (wdog_d == TIMEOUT[WDW-1:0]);

  // Command payload needs no reset: it is only observed once a valid is raised.
  always_ff @(posedge s_axi_aclk) begin
    if (cmd_tvalid && cmd_tready_q) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q       <= IDLE;
      wdog_q        <= '0;
      cmd_tready_q  <= 1'b1;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      is_wr_q       <= 1'b0;
      rsp_tvalid_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_status_q  <= 2'b00;
      rsp_rdata_q   <= '0;
    end else begin
      // A raised request valid is only ever lowered by its own handshake, in any state.
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmd_tvalid && cmd_tready_q) begin
            cmd_tready_q <= 1'b0;
            wdog_q       <= '0;
            is_wr_q      <= cmd_write;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end

        WR_REQ, WR_RSP, RD_REQ, RD_RSP: begin
          wdog_q <= wdog_d;
          if (b_hs || r_hs) begin
            // A completing response beats the watchdog firing in the same cycle.
            rsp_tvalid_q  <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_status_q  <= b_hs ? m_axi_bresp : m_axi_rresp;
            rsp_rdata_q   <= b_hs ? 32'h0 : m_axi_rdata;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            state_q       <= RESP;
          end else if (wdog_fire) begin
            rsp_tvalid_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_status_q  <= 2'b00;
            rsp_rdata_q   <= 32'h0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            state_q       <= RESP;
          end else if (state_q == WR_REQ && (aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RSP;
          end else if (state_q == RD_REQ && ar_hs) begin
            rready_q <= 1'b1;
            state_q  <= RD_RSP;
          end
        end

        RESP: begin
          if (rsp_tready) begin
            rsp_tvalid_q <= 1'b0;
            if (rsp_timeout_q) begin
              state_q <= DRAIN;
            end else begin
              cmd_tready_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end

        DRAIN: begin
          // Only open the response channel once every request beat has been taken.
          if (b_hs || r_hs) begin
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            cmd_tready_q <= 1'b1;
            state_q      <= IDLE;
          end else if (!awvalid_q && !wvalid_q && !arvalid_q) begin
            bready_q <= is_wr_q;
            rready_q <= !is_wr_q;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_tready    = cmd_tready_q;
  assign rsp_tvalid    = rsp_tvalid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a latency-configurable memory slave with a decode-error region,
// a vector table, hand-written corner sequences and a randomized run against a memory model.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_tvalid = 1'b0;
  logic        cmd_tready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_tvalid;
  logic        rsp_tready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        rsp_timeout;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.TIMEOUT(TO)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit is_derr(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int  k_aw = 0, k_w = 0, k_b = 0, k_ar = 0, k_r = 0;
  bit  aw_en = 1'b1, w_en = 1'b1, b_en = 1'b1, ar_en = 1'b1, r_en = 1'b1;
  int  aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int  aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
  int  b_owed = 0, r_owed = 0;
  bit  aw_pend = 1'b0, w_pend = 1'b0;
  logic [31:0] slv_awaddr = '0, slv_wdata = '0, slv_araddr = '0;
  logic [31:0] slv_mem [logic [31:0]];

  // Observe handshakes on the active edge (pre-update values).
  always @(posedge clk) begin
    if (rst) begin
      aw_pend = 1'b0; w_pend = 1'b0; b_owed = 0; r_owed = 0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) begin
        b_beats++; b_owed--;
        if (!is_derr(slv_awaddr)) slv_mem[slv_awaddr] = slv_wdata;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        r_beats++; r_owed--;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        aw_beats++; slv_awaddr = m_axi_awaddr; aw_pend = 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_beats++; slv_wdata = m_axi_wdata; w_pend = 1'b1;
        chk("wstrb", 32'(m_axi_wstrb), 32'hF);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_beats++; slv_araddr = m_axi_araddr; r_owed++;
      end
      if (aw_pend && w_pend) begin
        aw_pend = 1'b0; w_pend = 1'b0; b_owed++;
      end
    end
  end

  // Drive slave outputs on the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      m_axi_awready = m_axi_awvalid && aw_en && (aw_wait >= k_aw);
      aw_wait = m_axi_awvalid ? aw_wait + 1 : 0;
      m_axi_wready = m_axi_wvalid && w_en && (w_wait >= k_w);
      w_wait = m_axi_wvalid ? w_wait + 1 : 0;
      m_axi_arready = m_axi_arvalid && ar_en && (ar_wait >= k_ar);
      ar_wait = m_axi_arvalid ? ar_wait + 1 : 0;
      if (b_owed > 0) begin
        m_axi_bvalid = m_axi_bvalid || (b_en && b_wait >= k_b);
        m_axi_bresp  = is_derr(slv_awaddr) ? 2'b11 : 2'b00;
        b_wait++;
      end else begin
        m_axi_bvalid = 1'b0; b_wait = 0;
      end
      if (r_owed > 0) begin
        m_axi_rvalid = m_axi_rvalid || (r_en && r_wait >= k_r);
        m_axi_rresp  = is_derr(slv_araddr) ? 2'b11 : 2'b00;
        m_axi_rdata  = is_derr(slv_araddr) ? 32'hDEADBA5E :
                       (slv_mem.exists(slv_araddr) ? slv_mem[slv_araddr] : 32'h0);
        r_wait++;
      end else begin
        m_axi_rvalid = 1'b0; r_wait = 0;
      end
    end
  end

  // ---------------- command helpers ----------------
  int          res_lat;
  logic [31:0] res_rdata;
  logic [1:0]  res_status;
  logic        res_to;
  logic        res_v1;

  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_tvalid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_tready && n < 100) begin
      @(negedge clk); n++;
    end
    if (!cmd_tready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept: cmd_tready low for %0d cycles, want 1", n);
    end
    @(negedge clk);
    cmd_tvalid = 1'b0;
    res_v1 = m_axi_awvalid | m_axi_arvalid;
  endtask

  task automatic wait_rsp();
    res_lat = 1;
    while (!rsp_tvalid && res_lat < 200) begin
      @(negedge clk); res_lat++;
    end
    if (!rsp_tvalid) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait: rsp_tvalid low after %0d cycles, want 1", res_lat);
    end
    res_rdata = rsp_rdata; res_status = rsp_status; res_to = rsp_timeout;
  endtask

  task automatic consume(input int stall);
    repeat (stall) @(negedge clk);
    rsp_tready = 1'b1;
    @(negedge clk);
    rsp_tready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          l0;     // aw latency (write) / ar latency (read)
    int          l1;     // w latency
    int          l2;     // b latency (write) / r latency (read)
    int          lat;    // accept -> rsp_tvalid cycles
    logic [31:0] rdata;
    logic [1:0]  status;
  } vec_t;

  vec_t vecs [10];
  logic [31:0] mdl [logic [31:0]];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    int awb, wb, arb, rb, n, cyc, split;
    bit bad_flag, seen_vld;
    logic [31:0] s_rdata;
    logic [1:0]  s_status;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hCAFE_0001, 0, 0, 0, 3, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 32'hE000_0000, 32'h0,         0, 0, 0, 3, 32'hDEADBA5E,  2'b11};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 0, 4, 0, 7, 32'h0,         2'b00};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         2, 0, 1, 6, 32'hCAFE_0001, 2'b00};
    vecs[4] = '{1'b0, 32'h0000_0020, 32'h0,         0, 0, 3, 6, 32'h1234_5678, 2'b00};
    vecs[5] = '{1'b1, 32'hE000_0004, 32'h5A5A_5A5A, 3, 1, 2, 8, 32'h0,         2'b11};
    vecs[6] = '{1'b0, 32'hE000_0004, 32'h0,         0, 0, 0, 3, 32'hDEADBA5E,  2'b11};
    vecs[7] = '{1'b0, 32'h0000_0030, 32'h0,         0, 0, 0, 3, 32'h0,         2'b00};
    vecs[8] = '{1'b1, 32'h0000_0010, 32'h0000_BEEF, 1, 1, 1, 5, 32'h0,         2'b00};
    vecs[9] = '{1'b0, 32'h0000_0010, 32'h0,         0, 0, 0, 3, 32'h0000_BEEF, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_tready", 32'(cmd_tready), 32'd1);
    chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_tvalid}), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_status_to", 32'({rsp_status, rsp_timeout}), 32'd0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      k_aw = vecs[i].l0; k_ar = vecs[i].l0; k_w = vecs[i].l1; k_b = vecs[i].l2; k_r = vecs[i].l2;
      awb = aw_beats; wb = w_beats; arb = ar_beats;
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_valid_1cyc", i), 32'(res_v1), 32'd1);
      wait_rsp();
      chk($sformatf("v%0d_latency", i), 32'(res_lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_rdata", i), res_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_status", i), 32'(res_status), 32'(vecs[i].status));
      chk($sformatf("v%0d_timeout", i), 32'(res_to), 32'd0);
      consume(0);
      chk($sformatf("v%0d_aw_beats", i), 32'(aw_beats - awb), 32'(vecs[i].wr));
      chk($sformatf("v%0d_w_beats", i), 32'(w_beats - wb), 32'(vecs[i].wr));
      chk($sformatf("v%0d_ar_beats", i), 32'(ar_beats - arb), 32'(!vecs[i].wr));
    end

    // awready 4 cycles ahead of wready: awvalid drops, wvalid holds
    k_aw = 0; k_w = 4; k_b = 0;
    awb = aw_beats; wb = w_beats;
    send_cmd(1'b1, 32'h24, 32'hA5A5_0024);
    split = 0; n = 0; bad_flag = 1'b0;
    while (m_axi_wvalid && n < 20) begin
      if (!m_axi_awvalid) split++;
      @(negedge clk); n++;
    end
    chk("split_wvalid_done", 32'(m_axi_wvalid), 32'd0);
    chk("split_aw_low_w_high_cycles", 32'(split), 32'd4);
    chk("split_awvalid_after", 32'(m_axi_awvalid), 32'd0);
    wait_rsp();
    chk("split_status", 32'({res_status, res_to}), 32'd0);
    consume(0);
    chk("split_aw_beats", 32'(aw_beats - awb), 32'd1);
    chk("split_w_beats", 32'(w_beats - wb), 32'd1);

    // rsp_tready held low 10 cycles
    k_aw = 0; k_w = 0; k_ar = 0; k_r = 0; k_b = 0;
    send_cmd(1'b0, 32'hE000_0008, 32'h0);
    wait_rsp();
    s_rdata = rsp_rdata; s_status = rsp_status;
    bad_flag = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!rsp_tvalid || cmd_tready || rsp_rdata !== s_rdata || rsp_status !== s_status) bad_flag = 1'b1;
      @(negedge clk);
    end
    chk("hold_stable_and_busy", 32'(bad_flag), 32'd0);
    chk("hold_rdata", s_rdata, 32'hDEADBA5E);
    rsp_tready = 1'b1;
    @(negedge clk);
    rsp_tready = 1'b0;
    chk("hold_rsp_tvalid_drop", 32'(rsp_tvalid), 32'd0);
    chk("hold_idle_next_cycle", 32'(cmd_tready), 32'd1);

    // Watchdog: slave never raises arready until cycle 40
    ar_en = 1'b0;
    arb = ar_beats; rb = r_beats;
    send_cmd(1'b0, 32'h50, 32'h0);
    wait_rsp();
    chk("to_latency", 32'(res_lat), 32'(TO + 1));
    chk("to_flag", 32'(res_to), 32'd1);
    chk("to_status", 32'(res_status), 32'd0);
    chk("to_arvalid_held", 32'(m_axi_arvalid), 32'd1);
    consume(0);
    cyc = res_lat + 1;
    bad_flag = 1'b0; seen_vld = 1'b0;
    while (cyc < 40) begin
      if (cmd_tready || !m_axi_arvalid) bad_flag = 1'b1;
      if (rsp_tvalid) seen_vld = 1'b1;
      @(negedge clk); cyc++;
    end
    chk("drain_busy_ar_held", 32'(bad_flag), 32'd0);
    ar_en = 1'b1;
    n = 0;
    while (!cmd_tready && n < 10) begin
      if (rsp_tvalid) seen_vld = 1'b1;
      @(negedge clk); n++;
    end
    chk("drain_returns_idle", 32'(cmd_tready), 32'd1);
    chk("drain_no_rsp", 32'(seen_vld), 32'd0);
    chk("drain_ar_beats", 32'(ar_beats - arb), 32'd1);
    chk("drain_r_absorbed", 32'(r_beats - rb), 32'd1);
    send_cmd(1'b1, 32'h54, 32'h0000_5454);
    wait_rsp();
    chk("post_drain_latency", 32'(res_lat), 32'd3);
    chk("post_drain_status", 32'({res_status, res_to}), 32'd0);
    consume(0);

    // Reset while waiting in WR_RSP
    b_en = 1'b0;
    send_cmd(1'b1, 32'h40, 32'h4040_4040);
    n = 0;
    while (!m_axi_bready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("rst_mid_in_wr_rsp", 32'(m_axi_bready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_tvalid}), 32'd0);
    rst = 1'b0; b_en = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd_tready", 32'(cmd_tready), 32'd1);
    send_cmd(1'b0, 32'h40, 32'h0);
    wait_rsp();
    chk("rst_mid_read_back", res_rdata, 32'h0);
    consume(0);

    // Randomized run against a memory model
    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [31:0] a, d, e_rd;
      logic [1:0]  e_st;
      int e_lat;
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 5) == 0) ? 32'hE000_0100 : 32'h100 + 32'(4 * $urandom_range(0, 7));
      d  = $urandom;
      k_aw = $urandom_range(0, 4); k_w = $urandom_range(0, 4); k_b = $urandom_range(0, 4);
      k_ar = $urandom_range(0, 4); k_r = $urandom_range(0, 4);
      if (wr) begin
        e_rd  = 32'h0;
        e_st  = is_derr(a) ? 2'b11 : 2'b00;
        e_lat = 3 + ((k_aw > k_w) ? k_aw : k_w) + k_b;
        if (!is_derr(a)) mdl[a] = d;
      end else begin
        e_rd  = is_derr(a) ? 32'hDEADBA5E : (mdl.exists(a) ? mdl[a] : 32'h0);
        e_st  = is_derr(a) ? 2'b11 : 2'b00;
        e_lat = 3 + k_ar + k_r;
      end
      send_cmd(wr, a, d);
      wait_rsp();
      chk($sformatf("rnd%0d_rdata", i), res_rdata, e_rd);
      chk($sformatf("rnd%0d_status", i), 32'({res_status, res_to}), 32'({e_st, 1'b0}));
      chk($sformatf("rnd%0d_latency", i), 32'(res_lat), 32'(e_lat));
      consume($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
